// File: rtl/fp_add_pkg.sv
// Shared definitions for the floating-point adder pipeline: field widths,
// special encodings, normaliser FSM states and the result pack helper.
package fp_add_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  function automatic logic [EXP_W+FRAC_W:0] pack_fp(
    input logic              sign,
    input logic [EXP_W-1:0]  exp,
    input logic [FRAC_W-1:0] frac
  );
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_add_normalize.sv
// Stage 3 of the FP adder: iterative normalisation, special-case handling and
// IEEE-754 packing. Define FPA_NORM_RNE_EN to round-to-nearest-even on carry.
module fp_add_normalize
  import fp_add_pkg::*;
#(
  parameter int unsigned EXP_W  = fp_add_pkg::EXP_W,
  parameter int unsigned FRAC_W = fp_add_pkg::FRAC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FRAC_W+1:0]         intmdt_sum2,
  input  logic [EXP_W-1:0]          exp_a2,
  input  logic                      sign_a2,
  input  logic                      sign_b2,
  input  logic                      xor2,
  input  logic                      s2,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [EXP_W+FRAC_W:0]     result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overflow,
  output logic                      underflow
);

  localparam logic [EXP_W:0] L_EXP_MAX = (EXP_W+1)'(EXP_MAX);
  localparam logic [EXP_W:0] L_EXP_ONE = (EXP_W+1)'(1);

  state_t                r_state, w_state_nxt;
  logic [FRAC_W+1:0]     r_mant, w_mant_nxt, w_mant_shr;
  logic [EXP_W:0]        r_exp, w_exp_nxt, w_exp_inc;
  logic                  r_sign, w_sign_nxt;
  logic                  r_xor, w_xor_nxt;
  logic [EXP_W+FRAC_W:0] r_result, w_result_nxt;
  logic                  r_ovf, w_ovf_nxt;
  logic                  r_unf, w_unf_nxt;
  logic                  w_unused;

  // xor2 is captured for debug visibility only
  assign w_unused = &{1'b0, r_xor};

  always_comb begin
    w_state_nxt  = r_state;
    w_mant_nxt   = r_mant;
    w_exp_nxt    = r_exp;
    w_sign_nxt   = r_sign;
    w_xor_nxt    = r_xor;
    w_result_nxt = r_result;
    w_ovf_nxt    = r_ovf;
    w_unf_nxt    = r_unf;
    w_exp_inc    = r_exp + 1'b1;
    w_mant_shr   = {1'b0, r_mant[FRAC_W+1:1]};
`ifdef FPA_NORM_RNE_EN
    // a carry out of this increment sets bit FRAC_W+1 and costs one more NORM pass
    if (r_mant[0] && w_mant_shr[0]) w_mant_shr = w_mant_shr + 1'b1;
`endif

    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_mant_nxt  = intmdt_sum2;
          w_exp_nxt   = {1'b0, exp_a2};
          w_sign_nxt  = s2 ? sign_b2 : sign_a2;
          w_xor_nxt   = xor2;
          w_ovf_nxt   = 1'b0;
          w_unf_nxt   = 1'b0;
          w_state_nxt = NORM;
        end
      end
      NORM: begin
        if (r_exp == L_EXP_MAX) begin
          w_result_nxt = (r_mant[FRAC_W-1:0] == '0) ? pack_fp(r_sign, '1, '0) : QNAN;
          w_state_nxt  = DONE;
        end else if (r_mant == '0) begin
          w_result_nxt = '0;
          w_state_nxt  = DONE;
        end else if (r_mant[FRAC_W+1]) begin
          w_mant_nxt = w_mant_shr;
          w_exp_nxt  = w_exp_inc;
          if (w_exp_inc == L_EXP_MAX) begin
            w_result_nxt = pack_fp(r_sign, '1, '0);
            w_ovf_nxt    = 1'b1;
            w_state_nxt  = DONE;
          end else if (!w_mant_shr[FRAC_W+1]) begin
            w_result_nxt = pack_fp(r_sign, w_exp_inc[EXP_W-1:0], w_mant_shr[FRAC_W-1:0]);
            w_state_nxt  = DONE;
          end
        end else if (r_mant[FRAC_W]) begin
          w_result_nxt = pack_fp(r_sign, r_exp[EXP_W-1:0], r_mant[FRAC_W-1:0]);
          w_state_nxt  = DONE;
        end else if (r_exp <= L_EXP_ONE) begin
          w_result_nxt = pack_fp(r_sign, '0, '0);
          w_unf_nxt    = 1'b1;
          w_state_nxt  = DONE;
        end else begin
          w_mant_nxt = r_mant << 1;
          w_exp_nxt  = r_exp - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mant   <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_xor    <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mant   <= w_mant_nxt;
      r_exp    <= w_exp_nxt;
      r_sign   <= w_sign_nxt;
      r_xor    <= w_xor_nxt;
      r_result <= w_result_nxt;
      r_ovf    <= w_ovf_nxt;
      r_unf    <= w_unf_nxt;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Directed bench for fp_add_normalize: a value-level normalisation model feeds
// a scoreboard that checks result, flags, latency and handshake every cycle.
module tb_fp_add_normalize;

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] intmdt_sum2;
  logic [7:0]  exp_a2;
  logic        sign_a2, sign_b2, xor2, s2;
  logic        in_valid, in_ready;
  logic [31:0] result;
  logic        out_valid, out_ready, overflow, underflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
    int          t0;
  } ent_t;

  ent_t q[$];
  bit   head_seen = 0;

  fp_add_normalize dut (
    .clk        (clk),
    .rst        (rst),
    .intmdt_sum2(intmdt_sum2),
    .exp_a2     (exp_a2),
    .sign_a2    (sign_a2),
    .sign_b2    (sign_b2),
    .xor2       (xor2),
    .s2         (s2),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .result     (result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Value-level reference: locate the leading one, then decide the outcome directly.
  function automatic ent_t model(input logic [24:0] sum, input int e, input logic sg);
    ent_t        m;
    logic [24:0] f;
    logic [24:0] sh;
    int          k;
    int          ee;
    m.res = '0; m.ovf = 1'b0; m.unf = 1'b0; m.lat = 2; m.t0 = 0;
    if (e == 255) begin
      m.res = (sum[22:0] == 23'h0) ? {sg, 8'hFF, 23'h0} : 32'h7FC00000;
    end else if (sum == 25'h0) begin
      m.res = 32'h0;
    end else if (sum[24]) begin
      f  = sum >> 1;
      ee = e + 1;
`ifdef FPA_NORM_RNE_EN
      if (sum[0] && f[0]) f = f + 25'd1;
`endif
      if (ee == 255) begin
        m.res = {sg, 8'hFF, 23'h0}; m.ovf = 1'b1;
      end else if (f[24]) begin
        ee    = ee + 1;
        m.lat = 3;
        if (ee == 255) begin m.res = {sg, 8'hFF, 23'h0}; m.ovf = 1'b1; end
        else m.res = {sg, 8'(ee), 23'h0};
      end else begin
        m.res = {sg, 8'(ee), f[22:0]};
      end
    end else begin
      k = 0;
      while (!sum[23-k]) k++;
      if (k == 0 || e - k >= 1) begin
        sh    = sum << k;
        m.res = {sg, 8'(e - k), sh[22:0]};
        m.lat = 2 + k;
      end else begin
        m.res = {sg, 31'h0};
        m.unf = 1'b1;
        m.lat = 2 + ((e > 1) ? e - 1 : 0);
      end
    end
    return m;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      head_seen = 0;
    end else if (out_valid && out_ready && q.size() > 0) begin
      void'(q.pop_front());
      head_seen = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        chk("result", result, q[0].res);
        chk("overflow", {31'h0, overflow}, {31'h0, q[0].ovf});
        chk("underflow", {31'h0, underflow}, {31'h0, q[0].unf});
        chk("in_ready_while_done", {31'h0, in_ready}, 32'd0);
        if (!head_seen) begin
          chk("latency", cyc - q[0].t0, q[0].lat);
          head_seen = 1;
        end
      end
    end
  end

  task automatic send(input logic [24:0] sum, input logic [7:0] e, input logic sa,
                      input logic sb, input logic x, input logic s);
    int   n = 0;
    ent_t m;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_wait", {31'h0, in_ready}, 32'd1);
    intmdt_sum2 = sum; exp_a2 = e; sign_a2 = sa; sign_b2 = sb; xor2 = x; s2 = s;
    in_valid = 1'b1;
    m    = model(sum, int'(e), s ? sb : sa);
    m.t0 = cyc;
    q.push_back(m);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 80) begin @(negedge clk); n++; end
    chk("drain_timeout", q.size(), 32'd0);
  endtask

  ent_t pm;
  int   n;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    intmdt_sum2 = '0; exp_a2 = '0; sign_a2 = 0; sign_b2 = 0; xor2 = 0; s2 = 0;

    pm = model(25'h1000000, 127, 1'b0);
    chk("pin_1p1_res", pm.res, 32'h40000000);
    chk("pin_1p1_lat", pm.lat, 32'd2);
    pm = model(25'h0400000, 127, 1'b0);
    chk("pin_shift1_res", pm.res, 32'h3F000000);
    chk("pin_shift1_lat", pm.lat, 32'd3);
    pm = model(25'h0000000, 127, 1'b1);
    chk("pin_zero_res", pm.res, 32'h00000000);
    pm = model(25'h1000000, 254, 1'b0);
    chk("pin_ovf_res", pm.res, 32'h7F800000);
    chk("pin_ovf_flag", {31'h0, pm.ovf}, 32'd1);
    pm = model(25'h0000001, 3, 1'b0);
    chk("pin_unf_res", pm.res, 32'h00000000);
    chk("pin_unf_flag", {31'h0, pm.unf}, 32'd1);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {30'h0, overflow, underflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send(25'h1000000, 8'd127, 0, 0, 0, 0); drain();
    send(25'h0400000, 8'd127, 0, 0, 0, 0); drain();
    send(25'h0000000, 8'd127, 1, 0, 1, 0); drain();
    send(25'h1000000, 8'd254, 0, 0, 0, 0); drain();
    send(25'h0000001, 8'd3,   0, 0, 0, 0); drain();
    send(25'h0FFFFFF, 8'd200, 0, 0, 0, 0); drain();
    send(25'h0800000, 8'd255, 0, 1, 1, 1); drain();
    send(25'h0800001, 8'd255, 1, 0, 1, 0); drain();
    send(25'h0000001, 8'd100, 1, 0, 0, 0); drain();
    send(25'h1000003, 8'd10,  0, 1, 1, 1); drain();
    send(25'h0400000, 8'd2,   0, 1, 1, 1); drain();
    send(25'h0400000, 8'd1,   1, 0, 1, 0); drain();
    send(25'h0A5A5A5, 8'd0,   0, 0, 0, 0); drain();
    send(25'h1FFFFFF, 8'd253, 0, 0, 0, 0); drain();

    // backpressure: result and flags must hold while out_ready is low
    out_ready = 1'b0;
    send(25'h0123456, 8'd90, 1, 1, 0, 0);
    n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    chk("bp_out_valid", {31'h0, out_valid}, 32'd1);
    repeat (5) @(negedge clk);
    chk("bp_still_valid", {31'h0, out_valid}, 32'd1);
    out_ready = 1'b1;
    drain();

    // reset in the middle of a long shift sequence
    send(25'h0000001, 8'd100, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("mid_norm_busy", {31'h0, in_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    send(25'h1000000, 8'd127, 0, 0, 0, 0); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
